// File: rtl/dac_serializer.sv
// dac_serializer: buffers stereo samples in a small FIFO and shifts them out
// left-justified, MSB first, on AUD_DACDAT, framed by the codec's AUD_BCLK
// and AUD_DACLRCK. All state lives in the CLOCK_50 domain.
module dac_serializer #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   write,
    input  logic [WIDTH-1:0]       writedata_left,
    input  logic [WIDTH-1:0]       writedata_right,
    output logic                   write_ready,
    input  logic                   AUD_BCLK,
    input  logic                   AUD_DACLRCK,
    output logic                   AUD_DACDAT,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   underflow,
    output logic                   underflow_seen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] FIRST_BIT = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Codec clock synchronizers and edge strobes
    // ------------------------------------------------------------------
    logic bclk_meta, bclk_sync, bclk_hist;
    logic lrck_meta, lrck_sync, lrck_hist;
    logic bclk_fall, lrck_rise, lrck_fall;

    // Two-flop synchronizers plus a history flop for each codec clock.
    // These are deliberately not reset: clearing them while a pin sits high
    // would fake a rising edge on release and start a frame mid-way.
    // NOTE: every sequential block uses non-blocking (<=) assignments so all
    // flops sample the pre-edge values, exactly as the hardware does.
    always_ff @(posedge CLOCK_50) begin
        bclk_meta <= AUD_BCLK;
        bclk_sync <= bclk_meta;
        bclk_hist <= bclk_sync;
        lrck_meta <= AUD_DACLRCK;
        lrck_sync <= lrck_meta;
        lrck_hist <= lrck_sync;
    end

    // Registered one-cycle edge strobes, three clocks after the pin edge.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bclk_fall <= 1'b0;
            lrck_rise <= 1'b0;
            lrck_fall <= 1'b0;
        end else begin
            bclk_fall <= bclk_hist & ~bclk_sync;
            lrck_rise <= ~lrck_hist & lrck_sync;
            lrck_fall <= lrck_hist & ~lrck_sync;
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO of {left, right} pairs
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               fifo_empty;
    logic               push, pop, pop_req;
    logic [WIDTH-1:0]   head_left, head_right;

    assign write_ready = (fifo_count != FULL_COUNT);
    assign fifo_empty  = (fifo_count == '0);
    // Acceptance uses the pre-pop count, so a full FIFO refuses a write even
    // in the cycle a frame start frees a slot.
    assign push        = write && write_ready;
    // A frame start on an empty FIFO pops nothing; a same-cycle push is kept.
    assign pop         = pop_req && !fifo_empty;
    assign {head_left, head_right} = mem[rd_ptr];

    // Sample storage: written on every accepted push.
    // NOTE: the storage array has no reset; fifo_count alone says which
    // entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem[wr_ptr] <= {writedata_left, writedata_right};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t state, state_next;
    logic   load_left, load_right, shift_en;

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle actions. LRCK edges take priority over a
    // coincident BCLK fall, which is then simply dropped.
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        load_left  = 1'b0;
        load_right = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                if (lrck_rise) begin
                    state_next = LEFT;
                    load_left  = 1'b1;
                end
            end
            LEFT, RIGHT: begin
                if (lrck_rise) begin
                    state_next = LEFT;
                    load_left  = 1'b1;
                end else if (lrck_fall) begin
                    state_next = RIGHT;
                    load_right = 1'b1;
                end else if (bclk_fall) begin
                    shift_en = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop_req = load_left;

    // ------------------------------------------------------------------
    // Shift register, bit counter and serial output
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] hold_r;
    logic [CNT_W-1:0] bit_cnt;

    // Load on channel start, shift on BCLK falls, pad with zeros once all
    // WIDTH bits of the channel have been presented.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sr             <= '0;
            hold_r         <= '0;
            bit_cnt        <= '0;
            AUD_DACDAT     <= 1'b0;
            underflow      <= 1'b0;
            underflow_seen <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (load_left) begin
                bit_cnt <= FIRST_BIT;
                if (fifo_empty) begin
                    sr             <= '0;
                    hold_r         <= '0;
                    AUD_DACDAT     <= 1'b0;
                    underflow      <= 1'b1;
                    underflow_seen <= 1'b1;
                end else begin
                    sr         <= head_left;
                    hold_r     <= head_right;
                    AUD_DACDAT <= head_left[WIDTH-1];
                end
            end else if (load_right) begin
                bit_cnt    <= FIRST_BIT;
                sr         <= hold_r;
                AUD_DACDAT <= hold_r[WIDTH-1];
            end else if (shift_en) begin
                if (bit_cnt < LAST_BIT) begin
                    sr         <= {sr[WIDTH-2:0], 1'b0};
                    AUD_DACDAT <= sr[WIDTH-2];
                    bit_cnt    <= bit_cnt + 1'b1;
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_serializer.sv
// tb_dac_serializer: drives codec-style BCLK/LRCK framing, captures the serial
// stream on BCLK rises and compares each channel with a queue-based model.
`timescale 1ns/1ps
module tb_dac_serializer;

    localparam int WIDTH = 24;
    localparam int DEPTH = 4;
    localparam int H     = 8;   // CLOCK_50 cycles per BCLK half-period

    typedef struct packed {
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] r;
    } pair_t;

    logic             CLOCK_50 = 1'b0;
    logic             reset = 1'b1;
    logic             write = 1'b0;
    logic [WIDTH-1:0] writedata_left = '0;
    logic [WIDTH-1:0] writedata_right = '0;
    logic             write_ready;
    logic             AUD_BCLK = 1'b0;
    logic             AUD_DACLRCK = 1'b0;
    logic             AUD_DACDAT;
    logic [2:0]       fifo_count;
    logic             underflow;
    logic             underflow_seen;

    int n_pass  = 0;
    int n_total = 0;
    int uf_pulses = 0;
    int uf_long   = 0;
    logic uf_prev = 1'b0;

    pair_t model_q[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    dac_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .write           (write),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .write_ready     (write_ready),
        .AUD_BCLK        (AUD_BCLK),
        .AUD_DACLRCK     (AUD_DACLRCK),
        .AUD_DACDAT      (AUD_DACDAT),
        .fifo_count      (fifo_count),
        .underflow       (underflow),
        .underflow_seen  (underflow_seen)
    );

    // Count underflow pulses and any pulse longer than one cycle.
    always @(negedge CLOCK_50) begin
        if (underflow === 1'b1) uf_pulses++;
        if (underflow === 1'b1 && uf_prev === 1'b1) uf_long++;
        uf_prev = underflow;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        write = 1'b0;
        reset = 1'b1;
        tick(4);
        reset = 1'b0;
        model_q.delete();
    endtask

    task automatic push_pair(input pair_t p);
        bit accept;
        accept = (model_q.size() < DEPTH);
        write = 1'b1;
        writedata_left = p.l;
        writedata_right = p.r;
        tick(1);
        write = 1'b0;
        if (accept) model_q.push_back(p);
    endtask

    function automatic pair_t rand_pair();
        pair_t p;
        p.l = WIDTH'($urandom);
        p.r = WIDTH'($urandom);
        return p;
    endfunction

    // One channel period: LRCK is set together with a BCLK fall, then nbits
    // BCLK cycles; the bit is captured just before each BCLK rise.
    task automatic run_half(input logic lrck, input int nbits, input bit inject,
                            input pair_t inj, input int rst_bit,
                            output logic [WIDTH-1:0] got, output logic pad,
                            output logic rst_dat, output logic [2:0] rst_cnt);
        got = '0;
        pad = 1'b0;
        rst_dat = 1'b0;
        rst_cnt = '0;
        AUD_DACLRCK = lrck;
        AUD_BCLK = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0 && inject) begin
                tick(3);
                write = 1'b1;
                writedata_left = inj.l;
                writedata_right = inj.r;
                tick(1);
                write = 1'b0;
                tick(H - 4);
            end else if (i == rst_bit) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                rst_dat = AUD_DACDAT;
                rst_cnt = fifo_count;
                tick(H - 1);
            end else begin
                tick(H);
            end
            if (i < WIDTH) got = {got[WIDTH-2:0], AUD_DACDAT};
            else pad = pad | AUD_DACDAT;
            AUD_BCLK = 1'b1;
            tick(H);
            if (i < nbits - 1) AUD_BCLK = 1'b0;
        end
    endtask

    // Full frame; the model decides what should come out. A write injected
    // at the frame-start strobe is accepted only if the FIFO was not full
    // before the pop, and an empty FIFO sends zeros while keeping the push.
    task automatic run_frame(input int nbits, input bit inject, input pair_t inj,
                             output pair_t got, output logic pad,
                             output pair_t exp, output int exp_uf, output int uf_delta);
        bit accept;
        int uf0;
        logic pl, pr, rd;
        logic [2:0] rc;
        accept = inject && (model_q.size() < DEPTH);
        if (model_q.size() > 0) begin
            exp = model_q.pop_front();
            exp_uf = 0;
        end else begin
            exp = '0;
            exp_uf = 1;
        end
        if (accept) model_q.push_back(inj);
        uf0 = uf_pulses;
        run_half(1'b1, nbits, inject, inj, -1, got.l, pl, rd, rc);
        run_half(1'b0, nbits, 1'b0, inj, -1, got.r, pr, rd, rc);
        pad = pl | pr;
        uf_delta = uf_pulses - uf0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (AUD_DACDAT !== 1'b0) $display("FAIL reset_dacdat got=%b exp=0", AUD_DACDAT); else n_pass++;
        n_total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", fifo_count); else n_pass++;
        n_total++; if (write_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", write_ready); else n_pass++;
        n_total++; if (underflow !== 1'b0) $display("FAIL reset_underflow got=%b exp=0", underflow); else n_pass++;
        n_total++; if (underflow_seen !== 1'b0) $display("FAIL reset_seen got=%b exp=0", underflow_seen); else n_pass++;
    endtask

    task automatic test_basic();
        pair_t got, exp, p;
        logic pad;
        int exp_uf, uf_d;
        do_reset();
        p.l = 24'h800001;
        p.r = 24'h7FFFFE;
        push_pair(p);
        n_total++; if (fifo_count !== 3'd1) $display("FAIL basic_count got=%0d exp=1", fifo_count); else n_pass++;
        run_frame(WIDTH, 1'b0, '0, got, pad, exp, exp_uf, uf_d);
        n_total++; if (got.l !== 24'h800001) $display("FAIL basic_left got=%h exp=800001", got.l); else n_pass++;
        n_total++; if (got.r !== 24'h7FFFFE) $display("FAIL basic_right got=%h exp=7ffffe", got.r); else n_pass++;
        n_total++; if (uf_d !== 0) $display("FAIL basic_no_uf got=%0d exp=0", uf_d); else n_pass++;
        run_frame(WIDTH, 1'b0, '0, got, pad, exp, exp_uf, uf_d);
        n_total++; if (got !== pair_t'(0)) $display("FAIL basic_uf_data got=%h exp=0", got); else n_pass++;
        n_total++; if (uf_d !== 1) $display("FAIL basic_uf_pulses got=%0d exp=1", uf_d); else n_pass++;
        n_total++; if (underflow_seen !== 1'b1) $display("FAIL basic_seen got=%b exp=1", underflow_seen); else n_pass++;
        n_total++; if (uf_long !== 0) $display("FAIL basic_uf_width got=%0d exp=0", uf_long); else n_pass++;
    endtask

    task automatic test_fill();
        pair_t got, exp;
        logic pad;
        int exp_uf, uf_d;
        logic exp_ready;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp_ready = (model_q.size() < DEPTH);
            n_total++; if (write_ready !== exp_ready) $display("FAIL fill_ready_%0d got=%b exp=%b", k, write_ready, exp_ready); else n_pass++;
            push_pair(rand_pair());
        end
        n_total++; if (write_ready !== 1'b0) $display("FAIL fill_full_ready got=%b exp=0", write_ready); else n_pass++;
        n_total++; if (fifo_count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", fifo_count); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            run_frame(WIDTH + int'($urandom_range(0, 3)), 1'b0, '0, got, pad, exp, exp_uf, uf_d);
            n_total++; if (got !== exp) $display("FAIL fill_frame_%0d got=%h exp=%h", k, got, exp); else n_pass++;
            n_total++; if (pad !== 1'b0 || uf_d !== exp_uf) $display("FAIL fill_pad_uf_%0d pad=%b uf=%0d exp_uf=%0d", k, pad, uf_d, exp_uf); else n_pass++;
        end
        n_total++; if (fifo_count !== 3'd0) $display("FAIL fill_drained got=%0d exp=0", fifo_count); else n_pass++;
    endtask

    task automatic test_midframe();
        pair_t got, exp, p;
        logic pad;
        int exp_uf, uf_d, ones;
        AUD_DACLRCK = 1'b1;
        AUD_BCLK = 1'b0;
        do_reset();
        p.l = 24'hA5A5A5;
        p.r = 24'h5A5A5A;
        push_pair(p);
        ones = 0;
        for (int i = 0; i < 34; i++) begin
            if (i == 10) AUD_DACLRCK = 1'b0;
            AUD_BCLK = 1'b0;
            tick(H);
            if (AUD_DACDAT !== 1'b0) ones++;
            AUD_BCLK = 1'b1;
            tick(H);
        end
        n_total++; if (ones !== 0) $display("FAIL mid_idle_quiet got=%0d nonzero bits exp=0", ones); else n_pass++;
        n_total++; if (fifo_count !== 3'd1) $display("FAIL mid_no_pop got=%0d exp=1", fifo_count); else n_pass++;
        run_frame(WIDTH, 1'b0, '0, got, pad, exp, exp_uf, uf_d);
        n_total++; if (got.l !== 24'hA5A5A5) $display("FAIL mid_left got=%h exp=a5a5a5", got.l); else n_pass++;
        n_total++; if (got.r !== 24'h5A5A5A) $display("FAIL mid_right got=%h exp=5a5a5a", got.r); else n_pass++;
    endtask

    task automatic test_full_pop();
        pair_t got, exp;
        logic pad;
        int exp_uf, uf_d;
        do_reset();
        for (int k = 0; k < 4; k++) push_pair(rand_pair());
        n_total++; if (fifo_count !== 3'd4) $display("FAIL fullpop_pre got=%0d exp=4", fifo_count); else n_pass++;
        run_frame(WIDTH, 1'b1, rand_pair(), got, pad, exp, exp_uf, uf_d);
        n_total++; if (got !== exp) $display("FAIL fullpop_frame got=%h exp=%h", got, exp); else n_pass++;
        n_total++; if (fifo_count !== 3'd3) $display("FAIL fullpop_count got=%0d exp=3", fifo_count); else n_pass++;
        n_total++; if (write_ready !== 1'b1) $display("FAIL fullpop_ready got=%b exp=1", write_ready); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            run_frame(WIDTH, 1'b0, '0, got, pad, exp, exp_uf, uf_d);
            n_total++; if (got !== exp || uf_d !== exp_uf) $display("FAIL fullpop_drain_%0d got=%h exp=%h uf=%0d exp_uf=%0d", k, got, exp, uf_d, exp_uf); else n_pass++;
        end
    endtask

    task automatic test_push_at_empty();
        pair_t got, exp, p;
        logic pad;
        int exp_uf, uf_d;
        do_reset();
        p = rand_pair();
        run_frame(WIDTH, 1'b1, p, got, pad, exp, exp_uf, uf_d);
        n_total++; if (got !== pair_t'(0)) $display("FAIL empty_push_zeros got=%h exp=0", got); else n_pass++;
        n_total++; if (uf_d !== 1) $display("FAIL empty_push_uf got=%0d exp=1", uf_d); else n_pass++;
        n_total++; if (fifo_count !== 3'd1) $display("FAIL empty_push_count got=%0d exp=1", fifo_count); else n_pass++;
        run_frame(WIDTH, 1'b0, '0, got, pad, exp, exp_uf, uf_d);
        n_total++; if (got !== p || uf_d !== 0) $display("FAIL empty_push_next got=%h exp=%h uf=%0d", got, p, uf_d); else n_pass++;
    endtask

    task automatic test_reset_mid();
        pair_t got, exp, p;
        logic pad, rd;
        logic [2:0] rc;
        int exp_uf, uf_d;
        do_reset();
        for (int k = 0; k < 3; k++) push_pair(rand_pair());
        run_frame(WIDTH, 1'b0, '0, got, pad, exp, exp_uf, uf_d);
        n_total++; if (got !== exp) $display("FAIL rstmid_first got=%h exp=%h", got, exp); else n_pass++;
        exp = model_q.pop_front();
        run_half(1'b1, WIDTH, 1'b0, '0, -1, got.l, pad, rd, rc);
        n_total++; if (got.l !== exp.l) $display("FAIL rstmid_left got=%h exp=%h", got.l, exp.l); else n_pass++;
        run_half(1'b0, WIDTH, 1'b0, '0, 10, got.r, pad, rd, rc);
        model_q.delete();
        n_total++; if (rd !== 1'b0) $display("FAIL rstmid_dacdat got=%b exp=0", rd); else n_pass++;
        n_total++; if (rc !== 3'd0) $display("FAIL rstmid_count got=%0d exp=0", rc); else n_pass++;
        p = rand_pair();
        push_pair(p);
        run_frame(WIDTH, 1'b0, '0, got, pad, exp, exp_uf, uf_d);
        n_total++; if (got !== p || uf_d !== 0) $display("FAIL rstmid_resume got=%h exp=%h uf=%0d", got, p, uf_d); else n_pass++;
    endtask

    task automatic test_random();
        pair_t got, exp;
        logic pad;
        int exp_uf, uf_d, n;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(0, 2));
            for (int j = 0; j < n; j++) push_pair(rand_pair());
            run_frame(WIDTH + int'($urandom_range(0, 4)), 1'b0, '0, got, pad, exp, exp_uf, uf_d);
            n_total++; if (got !== exp || pad !== 1'b0 || uf_d !== exp_uf)
                $display("FAIL random_%0d got=%h exp=%h pad=%b uf=%0d exp_uf=%0d", k, got, exp, pad, uf_d, exp_uf);
            else n_pass++;
            n_total++; if (fifo_count !== 3'(model_q.size())) $display("FAIL random_count_%0d got=%0d exp=%0d", k, fifo_count, model_q.size()); else n_pass++;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_midframe();
        test_full_pop();
        test_push_at_empty();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dac_serializer.md
# dac_serializer

Transmit-side audio block: accepts stereo 24-bit samples through the same `write`/`write_ready` handshake the filter datapath uses toward the codec, buffers them in a small FIFO, and shifts them out serially on `AUD_DACDAT`, framed by the codec-supplied `AUD_BCLK` and `AUD_DACLRCK`. It sits between the `CLOCK_50` processing logic and the DAC pins. It is the output half of the audio codec interface, the counterpart to the ADC deserializer feeding `readdata_left`/`readdata_right`.

## Interface
- `WIDTH`, 24, bits per channel sample
- `DEPTH`, 4, FIFO depth in stereo sample pairs (power of two, ≥2)

- `CLOCK_50`  in  1  system clock; all state is in this domain
- `reset`  in  1  synchronous, active-high reset
- `write`  in  1  push request; a pair is accepted when `write && write_ready`
- `writedata_left`  in  WIDTH  signed left sample
- `writedata_right`  in  WIDTH  signed right sample
- `write_ready`  out  1  FIFO has room (`fifo_count != DEPTH`)
- `AUD_BCLK`  in  1  codec bit clock, asynchronous to `CLOCK_50`
- `AUD_DACLRCK`  in  1  codec frame clock, asynchronous; high = left, low = right
- `AUD_DACDAT`  out  1  serial DAC data, registered
- `fifo_count`  out  $clog2(DEPTH)+1  stored pairs
- `underflow`  out  1  one-cycle pulse: a frame started with the FIFO empty
- `underflow_seen`  out  1  sticky underflow flag; cleared only by `reset`

## Operation
- `AUD_BCLK` and `AUD_DACLRCK` each pass through a 2-flop synchronizer plus one history flop. The block detects BCLK falling edges and DACLRCK rising/falling edges on the synchronized signals.
- FIFO: circular buffer of {left,right}, with read/write pointers that wrap modulo DEPTH.
  - Push on an accepted write.
  - Pop only at a DACLRCK rising edge.
  - `write_ready` is combinational from the current `fifo_count`. At count==DEPTH a write is not accepted, even if a pop occurs that cycle.
- FSM states:
  - IDLE: entered on reset. `AUD_DACDAT`=0. Ignores BCLK. Goes to LEFT on the first DACLRCK rising edge, so the block never starts mid-frame.
  - LEFT: on entry (DACLRCK rising edge), pop the FIFO.
    - If non-empty, load the left sample into shift register `sr`, latch the right sample into `hold_r`, and drive `sr[WIDTH-1]` (MSB) onto `AUD_DACDAT`.
    - If empty, load zeros into both and pulse `underflow`.
    - Reset the bit counter to 1.
    - Each BCLK falling edge: if counter < WIDTH, shift `sr` left and output the new MSB, then increment the counter. Otherwise output 0 (padding).
    - A DACLRCK falling edge moves to RIGHT.
  - RIGHT: on entry, load `hold_r` into `sr` and drive its MSB; counter resets to 1. Same shifting rule. A DACLRCK rising edge moves to LEFT, with a pop.
- Format is left-justified, MSB first: the MSB is valid from the LRCK edge through the first BCLK rise, then exactly WIDTH bits per channel, then zeros.
- An LRCK edge and a BCLK falling edge detected in the same cycle: the LRCK edge wins (load); that BCLK edge is ignored.
- A push and a frame-start pop in the same cycle with count==0: the pop sees empty (underflow, zeros sent); the push is stored; count ends at 1.
- A push and a pop in the same cycle with 0<count<DEPTH: count is unchanged.

## Timing
- Reset values: `AUD_DACDAT`=0, `fifo_count`=0, `write_ready`=1, `underflow`=0, `underflow_seen`=0, state IDLE, pointers 0.
- Reset mid-frame: FIFO flushed. `AUD_DACDAT`=0 on the cycle after `reset` is sampled high. The block waits in IDLE for the next DACLRCK rising edge.
- Edge detect latency: a pin edge produces an internal edge strobe 3 `CLOCK_50` cycles later. `AUD_DACDAT` updates on the following clock, 4 cycles after the pin edge. This is well inside a 50 MHz / BCLK half-period (BCLK ≤ 3.072 MHz).
- `fifo_count` and `write_ready` reflect a push on the clock after the accepting cycle.
- `underflow` is high for exactly one cycle: the cycle after the DACLRCK rising edge strobe. `underflow_seen` rises on the same cycle.

## Test plan
- After reset, push (L=24'h800001, R=24'h7FFFFE), then drive 2 frames of BCLK=48·fs with DACLRCK toggling -> `AUD_DACDAT` samples on BCLK rise read 1000…0001 for left and 0111…1110 for right, then zeros; the second frame underflows: `underflow` pulses once and `underflow_seen`=1.
- Push 5 pairs with no LRCK activity -> 4 accepted; `write_ready`=0 after the 4th; 5th ignored; `fifo_count`=4; the following frames emit pairs 1–4 in order.
- Start LRCK/BCLK mid-left-frame after reset with FIFO preloaded (A5A5A5/5A5A5A) -> `AUD_DACDAT`=0 until the next DACLRCK rise, then A5A5A5 sent complete.
- At count=4, write asserted on the same cycle as a frame-start pop -> write not accepted; count=3 afterward.
- At count=0, push coincident with the frame-start strobe -> zeros sent, `underflow` pulse, count=1; the next frame sends the pushed pair.
- Assert `reset` for 1 cycle at bit 10 of a right channel -> `AUD_DACDAT`=0 and `fifo_count`=0 next cycle; resumes cleanly at the next left frame.
